// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv
// Description : Iterative M-extension unit for the EX stage. It uses a radix-2
//               shift-add multiplier and a restoring divider, and shares one
//               pair of working registers between the two. Divide-by-zero and
//               signed overflow are resolved in a single cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [1:0]      forwardRs,
    input  logic [1:0]      forwardRt,
    input  logic [XLEN-1:0] rsData,
    input  logic [XLEN-1:0] rtData,
    input  logic [XLEN-1:0] memFwdData,
    input  logic [XLEN-1:0] wbFwdData,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int              c_CW   = $clog2(XLEN + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(XLEN);
    localparam logic [XLEN-1:0] c_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MUL  = 2'd1;
    localparam logic [1:0] c_DIV  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [2:0]      r_op;
    logic [XLEN-1:0] r_opa;      // multiplicand magnitude
    logic [XLEN-1:0] r_opb;      // divisor magnitude
    logic [XLEN-1:0] r_hi;       // product high half / partial remainder
    logic [XLEN-1:0] r_lo;       // multiplier bits + product low / quotient
    logic            r_negres;   // product or quotient must be negated
    logic            r_negrem;   // remainder must be negated
    logic [XLEN-1:0] r_result;

    logic [XLEN-1:0] w_a, w_b, w_a_mag, w_b_mag;
    logic            w_a_neg, w_b_neg, w_special;
    logic [XLEN-1:0] w_spec_res;
    logic [XLEN:0]   w_sum, w_shift;
    logic            w_ge;
    logic [XLEN-1:0] w_step_hi, w_step_lo;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0] w_mul_res, w_quo, w_rem, w_final;

    // Operand select from the forwarding network, then sign/magnitude and
    // special-case detection for the op being launched.
    always_comb begin
        case (forwardRs)
            2'b10:   w_a = memFwdData;
            2'b01:   w_a = wbFwdData;
            default: w_a = rsData;
        endcase
        case (forwardRt)
            2'b10:   w_b = memFwdData;
            2'b01:   w_b = wbFwdData;
            default: w_b = rtData;
        endcase
        // Divides: signed when funct3[0]=0. Multiplies: rs signed unless MULHU,
        // rt signed only for MUL/MULH.
        w_a_neg = w_a[XLEN-1] & (funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11));
        w_b_neg = w_b[XLEN-1] & (funct3[2] ? ~funct3[0] : ~funct3[1]);
        w_a_mag = w_a_neg ? -w_a : w_a;
        w_b_mag = w_b_neg ? -w_b : w_b;
        w_special  = 1'b0;
        w_spec_res = '0;
        if (funct3[2] && (w_b == '0)) begin
            w_special  = 1'b1;
            w_spec_res = funct3[1] ? w_a : '1;
        end else if (funct3[2] && !funct3[0] && (w_a == c_MIN) && (w_b == '1)) begin
            w_special  = 1'b1;
            w_spec_res = funct3[1] ? '0 : c_MIN;
        end
    end

    // One iteration step (shift-add or restoring subtract) and the final
    // sign correction / half selection applied on the way into DONE.
    always_comb begin
        w_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opa : '0)};
        w_shift = {r_hi, r_lo[XLEN-1]};
        w_ge    = (w_shift >= {1'b0, r_opb});
        if (r_op[2]) begin
            w_step_hi = w_ge ? (w_shift[XLEN-1:0] - r_opb) : w_shift[XLEN-1:0];
            w_step_lo = {r_lo[XLEN-2:0], w_ge};
        end else begin
            w_step_hi = w_sum[XLEN:1];
            w_step_lo = {w_sum[0], r_lo[XLEN-1:1]};
        end
        w_prod    = r_negres ? -{r_hi, r_lo} : {r_hi, r_lo};
        w_mul_res = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        w_quo     = r_negres ? -r_lo : r_lo;
        w_rem     = r_negrem ? -r_hi : r_hi;
        w_final   = r_op[2] ? (r_op[1] ? w_rem : w_quo) : w_mul_res;
    end

    // Control FSM and datapath registers; flush overrides everything else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_negres <= 1'b0;
            r_negrem <= 1'b0;
            r_result <= '0;
        end else if (flush) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_op     <= funct3;
                        r_cnt    <= '0;
                        r_opa    <= w_a_mag;
                        r_opb    <= w_b_mag;
                        r_hi     <= '0;
                        r_lo     <= funct3[2] ? w_a_mag : w_b_mag;
                        r_negres <= w_a_neg ^ w_b_neg;
                        r_negrem <= w_a_neg;
                        if (w_special) begin
                            r_result <= w_spec_res;
                            r_state  <= c_DONE;
                        end else begin
                            r_state <= funct3[2] ? c_DIV : c_MUL;
                        end
                    end
                end
                c_MUL, c_DIV: begin
                    // XLEN iterations, then one cycle to sign-correct the result.
                    if (r_cnt == c_LAST) begin
                        r_result <= w_final;
                        r_state  <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        r_hi  <= w_step_hi;
                        r_lo  <= w_step_lo;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign busy   = (r_state == c_MUL) || (r_state == c_DIV);
    assign done   = (r_state == c_DONE);
    assign stall  = (start && (r_state == c_IDLE)) || busy;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv
// Description : Scoreboard bench for ex_muldiv. The stimulus pushes expected
//               results and completion cycles; a monitor pops them on done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;
    localparam int XLEN = 32;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [1:0]  forwardRs = '0, forwardRt = '0;
    logic [31:0] rsData = '0, rtData = '0, memFwdData = '0, wbFwdData = '0;
    logic        stall, busy, done;
    logic [31:0] result;

    ex_muldiv #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .forwardRs(forwardRs), .forwardRt(forwardRt),
        .rsData(rsData), .rtData(rtData),
        .memFwdData(memFwdData), .wbFwdData(wbFwdData),
        .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] res; int cyc; } exp_t;
    exp_t sbq[$];
    int n_cmp = 0, n_err = 0;
    logic [31:0] last_exp = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: plain arithmetic on the architectural definitions.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ub = longint'({32'h0, b});
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: if (b == 0) return '1; else if (a == MINV && b == '1) return MINV;
                  else return int'(a) / int'(b);
            3'd5: if (b == 0) return '1; else return a / b;
            3'd6: if (b == 0) return a; else if (a == MINV && b == '1) return '0;
                  else return int'(a) % int'(b);
            default: if (b == 0) return a; else return a % b;
        endcase
    endfunction

    function automatic bit special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 0 || (!f[0] && a == MINV && b == '1));
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'd1;
            2: return '1;
            3: return MINV;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
            end else begin
                e = sbq.pop_front();
                chk("result", result, e.res);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Present an op (called at posedge+1) and return just after its accept edge.
    task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] fs, input logic [1:0] ft);
        if (fs == ft && (ft == 2'b10 || ft == 2'b01)) ft = 2'b00;
        funct3 = f; forwardRs = fs; forwardRt = ft;
        rsData = $urandom; rtData = $urandom; memFwdData = $urandom; wbFwdData = $urandom;
        case (fs) 2'b10: memFwdData = a; 2'b01: wbFwdData = a; default: rsData = a; endcase
        case (ft) 2'b10: memFwdData = b; 2'b01: wbFwdData = b; default: rtData = b; endcase
        start = 1'b1;
        @(negedge clk);
        chk("stall_on_start", {31'b0, stall}, 32'd1);
        @(posedge clk); #1;
        rsData = $urandom; rtData = $urandom; memFwdData = $urandom; wbFwdData = $urandom;
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] fs, input logic [1:0] ft, input bit hold);
        int lat;
        logic [31:0] e;
        e   = model(f, a, b);
        lat = special(f, a, b) ? 0 : XLEN + 1;
        if (lat == 0) hold = 1'b0;
        launch(f, a, b, fs, ft);
        sbq.push_back('{res: e, cyc: cyc + lat});
        last_exp = e;
        if (!hold) start = 1'b0;
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            chk("stall", {31'b0, stall}, (k < lat) ? 32'd1 : 32'd0);
            chk("busy",  {31'b0, busy},  (k < lat) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
            if (hold && k == lat - 1) start = 1'b0;
        end
        start = 1'b0;
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", result, 32'h0);
        chk("rst_busy",  {31'b0, busy},  32'd0);
        chk("rst_done",  {31'b0, done},  32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 2'b10, 2'b00, 1'b0);
        run_op(3'd3, '1, '1, 2'b00, 2'b01, 1'b0);
        run_op(3'd1, '1, '1, 2'b00, 2'b01, 1'b0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 2'b00, 2'b00, 1'b0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 2'b00, 2'b00, 1'b0);
        run_op(3'd5, 32'd100, 32'd0, 2'b00, 2'b00, 1'b0);
        run_op(3'd4, MINV, '1, 2'b00, 2'b00, 1'b0);
        run_op(3'd6, MINV, '1, 2'b00, 2'b00, 1'b0);

        // Flush at iteration 10 of a DIVU: no done, result held
        launch(3'd5, 32'd1000, 32'd7, 2'b00, 2'b00);
        start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy",   {31'b0, busy},  32'd0);
        chk("flush_stall",  {31'b0, stall}, 32'd0);
        chk("flush_result", result, last_exp);
        run_op(3'd5, 32'd1000, 32'd7, 2'b00, 2'b00, 1'b0);

        // Flush beats start in IDLE
        funct3 = 3'd0; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_prio_busy", {31'b0, busy}, 32'd0);

        // Reset at iteration 5 of a MUL
        launch(3'd0, 32'd12345, 32'd678, 2'b00, 2'b00);
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("midrst_result", result, 32'h0);
        chk("midrst_busy",  {31'b0, busy},  32'd0);
        chk("midrst_done",  {31'b0, done},  32'd0);
        chk("midrst_stall", {31'b0, stall}, 32'd0);
        last_exp = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Start held high while busy must yield one done pulse only
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 2'b10, 2'b00, 1'b1);

        // Randomized operations
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            if (f[2] && !f[0] && $urandom_range(0, 9) == 0) begin a = MINV; b = '1; end
            run_op(f, a, b, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0));
        end

        repeat (5) @(posedge clk);
        while (sbq.size() > 0) begin
            void'(sbq.pop_front());
            n_cmp++;
            n_err++;
            $display("FAIL missing_done: got no done expected done pulse");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL have one parameter: XLEN, default 32, operand and result width in bits.
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  EX-stage M-extension op valid.
- funct3  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- forwardRs  in  2  rs operand source select from the forwarding unit.
- forwardRt  in  2  rt operand source select from the forwarding unit.
- rsData  in  XLEN  rs value from the ID/EX register.
- rtData  in  XLEN  rt value from the ID/EX register.
- memFwdData  in  XLEN  EX/MEM ALU result.
- wbFwdData  in  XLEN  MEM/WB write-back data.
- flush  in  1  abort the current op.
- stall  out  1  hold the upstream pipeline.
- busy  out  1  iteration in progress.
- done  out  1  one-cycle result-valid strobe.
- result  out  XLEN  op result.

Function
REQ-003 Operand select SHALL be identical for rs and rt: 10 selects memFwdData, 01 selects wbFwdData, 00 or 11 selects rsData/rtData.
REQ-004 The FSM SHALL have states IDLE, MUL, DIV, DONE.
REQ-005 In IDLE, start=1 SHALL latch both selected operands and funct3 at the clock edge and transition as follows:
- funct3[2]=0 -> MUL.
- funct3[2]=1 -> DIV.
- special-case divide -> DONE.
REQ-006 start SHALL be ignored in MUL, DIV and DONE.
REQ-007 MUL SHALL use a radix-2 shift-add on operand magnitudes over exactly XLEN cycles, then go to DONE.
- Sign correction: MUL/MULH signed x signed; MULHSU signed x unsigned; MULHU unsigned.
REQ-008 DIV SHALL use a restoring shift-subtract on magnitudes over exactly XLEN cycles, then go to DONE.
- Quotient sign = XOR of operand signs (signed ops only).
- Remainder sign = dividend sign.
REQ-009 MUL SHALL return the low XLEN bits of the product; MULH, MULHSU and MULHU SHALL return the high XLEN bits.
REQ-010 Divide by zero SHALL give DIV/DIVU = all ones and REM/REMU = dividend, reaching DONE one cycle after start.
REQ-011 Signed overflow (dividend 0x80000000, divisor 0xFFFFFFFF, DIV/REM) SHALL give quotient 0x80000000 and remainder 0, reaching DONE one cycle after start.
REQ-012 Normal latency SHALL be fixed: done=1 in the cycle following edge N+XLEN+1, where N is the edge at which start is accepted.
REQ-013 DONE SHALL last one cycle: done=1, result valid, then IDLE unconditionally.
REQ-014 result SHALL be registered, update only on entry to DONE, and hold its value otherwise.
REQ-015 busy SHALL be 1 exactly in MUL or DIV.
REQ-016 stall SHALL be combinational: (start AND IDLE) OR busy; it SHALL be 0 in DONE so the instruction retires.
REQ-017 flush=1 SHALL force IDLE at the next edge from any state.
- done is not asserted; result is unchanged.
- flush SHALL take priority over start in the same cycle.
REQ-018 The block SHALL NOT contain an iteration counter wider than needed to count XLEN cycles, and the counter SHALL reset to 0 on every accepted start.

Reset
REQ-019 rst=1 SHALL asynchronously force: state IDLE, counter 0, result 0, busy 0, done 0, internal operand registers 0.
REQ-020 stall SHALL be 0 during reset whenever start=0.
REQ-021 After rst deasserts, the first accepted start SHALL behave identically to any later one.
REQ-022 rst asserted mid-operation SHALL discard the op with no done pulse.

Verification
REQ-023 MUL, rs=7 via forwardRs=10 (memFwdData=7), rt=-3 via rtData -> done in cycle 33 after the start edge, result 0xFFFFFFEB, stall high cycles 0-32.
REQ-024 MULHU 0xFFFFFFFF x 0xFFFFFFFF with forwardRt=01 (wbFwdData) -> result 0xFFFFFFFE; MULH of the same values -> 0x00000000.
REQ-025 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/0 -> 0xFFFFFFFF with done one cycle after start.
REQ-026 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in one cycle; REM of the same -> 0.
REQ-027 Start DIVU, assert flush at iteration 10 -> IDLE next edge, no done, result keeps its prior value; a new start is then accepted normally.
REQ-028 Assert rst at iteration 5 of a MUL -> outputs zero immediately, no done; a start held during busy is ignored (single done pulse only).
